// File: rtl/lcd_send_seq.sv
// lcd_send_seq: writes a string to the LCD through the rq/ack command driver (4- or 8-bit bus).
// Define LCD_SEND_SEQ_WRAP_EN to re-issue Set DD RAM Address at line ends.
module lcd_send_seq #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned LINE_LEN  = 16,
  parameter logic [6:0]  LINE2_ADS = 7'h40,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned DEL_W     = 18,
  parameter int unsigned DEL_SHORT = 30,
  parameter int unsigned DEL_LONG  = 2000,
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1),
  localparam int unsigned IDX_W    = $clog2(MAX_LEN)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              powerUp_i,
  input  logic              rq_i,
  output logic              ack_o,
  output logic              busy_o,
  input  logic [6:0]        ads_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [IDX_W-1:0]  charIdx_o,
  input  logic [7:0]        char_i,
  output logic              rq_o,
  input  logic              ack_i,
  output logic              rqRs_o,
  output logic              rqRw_o,
  output logic [DATA_W-1:0] rqData_o,
  output logic [DEL_W-1:0]  rqDel_o
);

  typedef enum logic [2:0] {StIdle, StAdsHi, StAdsLo, StDatHi, StDatLo, StDone} state_e;

  // An 8-bit bus sends whole bytes from the *Lo states only.
  localparam state_e StAdsFirst = (DATA_W == 8) ? StAdsLo : StAdsHi;
  localparam state_e StDatFirst = (DATA_W == 8) ? StDatLo : StDatHi;

  state_e             state_q, state_d;
  logic               rq_q, rq_d;
  logic               rs_q, rs_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DEL_W-1:0]   del_q, del_d;
  logic [6:0]         ads_q, ads_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               cmd_hi;
  logic               cmd_dat;
  logic [7:0]         cmd_byte;
  logic [DATA_W-1:0]  cmd_data;
  logic [6:0]         ads_inc;
  logic [6:0]         ads_next;
  logic               wrap;

  assign ads_inc = ads_q + 7'd1;

`ifdef LCD_SEND_SEQ_WRAP_EN
  always_comb begin
    wrap     = 1'b1;
    ads_next = ads_inc;
    if (ads_inc == 7'(LINE_LEN)) begin
      ads_next = LINE2_ADS;
    end else if (ads_inc == LINE2_ADS + 7'(LINE_LEN)) begin
      ads_next = 7'd0;
    end else begin
      wrap = 1'b0;
    end
  end
`else
  assign wrap     = 1'b0;
  assign ads_next = ads_inc;
`endif

  always_comb begin
    cmd_hi   = (state_q == StAdsHi) || (state_q == StDatHi);
    cmd_dat  = (state_q == StDatHi) || (state_q == StDatLo);
    cmd_byte = cmd_dat ? char_i : {1'b1, ads_q};
    cmd_data = (DATA_W == 8) ? cmd_byte[DATA_W-1:0]
                             : DATA_W'(cmd_hi ? cmd_byte[7:4] : cmd_byte[3:0]);
  end

  always_comb begin
    state_d = state_q;
    rq_d    = rq_q;
    rs_d    = rs_q;
    data_d  = data_q;
    del_d   = del_q;
    ads_d   = ads_q;
    rem_d   = rem_q;
    idx_d   = idx_q;

    case (state_q)
      StIdle: begin
        if (rq_i && !powerUp_i) begin
          ads_d   = ads_i;
          rem_d   = len_i;
          idx_d   = '0;
          state_d = (len_i == '0) ? StDone : StAdsFirst;
        end
      end

      StAdsHi, StAdsLo, StDatHi, StDatLo: begin
        // rq_q low inside a command state means the state was just entered.
        if (!rq_q) begin
          rq_d   = 1'b1;
          rs_d   = cmd_dat;
          data_d = cmd_data;
          del_d  = cmd_hi ? DEL_W'(DEL_SHORT) : DEL_W'(DEL_LONG);
        end else if (ack_i) begin
          rq_d = 1'b0;
          unique case (state_q)
            StAdsHi: state_d = StAdsLo;
            StAdsLo: state_d = StDatFirst;
            StDatHi: state_d = StDatLo;
            default: begin
              idx_d = idx_q + IDX_W'(1);
              rem_d = rem_q - LEN_W'(1);
              ads_d = ads_next;
              if (rem_q == LEN_W'(1)) begin
                state_d = StDone;
              end else if (wrap) begin
                state_d = StAdsFirst;
              end else begin
                state_d = StDatFirst;
              end
            end
          endcase
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rq_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      del_q   <= '0;
      ads_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rq_q    <= rq_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      del_q   <= del_d;
      ads_q   <= ads_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  assign ack_o     = (state_q == StDone);
  assign busy_o    = (state_q != StIdle) && (state_q != StDone);
  assign charIdx_o = idx_q;
  assign rq_o      = rq_q;
  assign rqRs_o    = rs_q;
  assign rqRw_o    = 1'b0;
  assign rqData_o  = data_q;
  assign rqDel_o   = del_q;

endmodule

// File: tb/tb_lcd_send_seq.sv
// Directed bench for lcd_send_seq: a 4-bit and an 8-bit instance, each served by a driver model
// that acks three cycles after rq_o and logs every command.
module tb_lcd_send_seq;

  localparam logic [17:0] S = 18'd30;
  localparam logic [17:0] L = 18'd2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pu;
  logic       rq4, rq8;
  logic [6:0] ads;
  logic [5:0] len;
  logic [7:0] buf4 [32];
  logic [7:0] buf8 [32];

  logic        ack4_o, busy4, rq4_o, rs4, rw4, ackin4;
  logic [4:0]  idx4;
  logic [7:0]  ch4;
  logic [3:0]  d4;
  logic [17:0] del4;

  logic        ack8_o, busy8, rq8_o, rs8, rw8, ackin8;
  logic [4:0]  idx8;
  logic [7:0]  ch8;
  logic [7:0]  d8;
  logic [17:0] del8;

  assign ch4 = buf4[idx4];
  assign ch8 = buf8[idx8];

  lcd_send_seq dut4 (
    .clk_i(clk), .reset_i(reset), .powerUp_i(pu), .rq_i(rq4), .ack_o(ack4_o), .busy_o(busy4),
    .ads_i(ads), .len_i(len), .charIdx_o(idx4), .char_i(ch4), .rq_o(rq4_o), .ack_i(ackin4),
    .rqRs_o(rs4), .rqRw_o(rw4), .rqData_o(d4), .rqDel_o(del4)
  );

  lcd_send_seq #(.DATA_W(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .powerUp_i(pu), .rq_i(rq8), .ack_o(ack8_o), .busy_o(busy8),
    .ads_i(ads), .len_i(len), .charIdx_o(idx8), .char_i(ch8), .rq_o(rq8_o), .ack_i(ackin8),
    .rqRs_o(rs8), .rqRw_o(rw8), .rqData_o(d8), .rqDel_o(del8)
  );

  // Driver models: ack three cycles after rq_o rises, log {rs, data, del}.
  logic [26:0] log4[$];
  logic [26:0] log8[$];
  int cnt4 = 0, cnt8 = 0;
  int acks4 = 0, acks8 = 0;
  int busyack4 = 0, busyack8 = 0;
  initial begin
    ackin4 = 1'b0;
    ackin8 = 1'b0;
  end

  always @(negedge clk) begin
    if (!rq4_o) begin
      cnt4   <= 0;
      ackin4 <= 1'b0;
    end else if (!ackin4) begin
      if (cnt4 == 2) begin
        ackin4 <= 1'b1;
        cnt4   <= 0;
        log4.push_back({rs4, 4'h0, d4, del4});
      end else begin
        cnt4 <= cnt4 + 1;
      end
    end
    if (ack4_o) begin
      acks4 <= acks4 + 1;
      if (busy4) busyack4 <= busyack4 + 1;
    end
  end

  always @(negedge clk) begin
    if (!rq8_o) begin
      cnt8   <= 0;
      ackin8 <= 1'b0;
    end else if (!ackin8) begin
      if (cnt8 == 2) begin
        ackin8 <= 1'b1;
        cnt8   <= 0;
        log8.push_back({rs8, d8, del8});
      end else begin
        cnt8 <= cnt8 + 1;
      end
    end
    if (ack8_o) begin
      acks8 <= acks8 + 1;
      if (busy8) busyack8 <= busyack8 + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] mk(input logic rs, input logic [7:0] d, input logic [17:0] del);
    return {rs, d, del};
  endfunction

  task automatic cmp_log(input string tag, input logic [26:0] got[$], input logic [26:0] exp[$]);
    check({tag, " count"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) check($sformatf("%s req%0d", tag, i), got[i], exp[i]);
    end
  endtask

  task automatic start(input bit w8, input logic [6:0] a, input logic [5:0] n);
    @(negedge clk);
    ads = a;
    len = n;
    if (w8) rq8 = 1'b1;
    else    rq4 = 1'b1;
    @(negedge clk);
    rq4 = 1'b0;
    rq8 = 1'b0;
  endtask

  task automatic wait_done(input bit w8, input int a0);
    int n = 0;
    while (((w8 ? acks8 : acks4) == a0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n < 2000, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  logic [26:0] ex[$];
  int a0;
  int seen;
  int n;

  initial begin
    reset = 1'b1;
    pu    = 1'b0;
    rq4   = 1'b0;
    rq8   = 1'b0;
    ads   = '0;
    len   = '0;
    foreach (buf4[i]) begin
      buf4[i] = 8'h20;
      buf8[i] = 8'h20;
    end
    repeat (3) @(negedge clk);
    check("rst rq_o", rq4_o, 1'b0);
    check("rst ack_o", ack4_o, 1'b0);
    check("rst busy_o", busy4, 1'b0);
    check("rst charIdx", idx4, 5'd0);
    check("rst data", d4, 4'd0);
    check("rst del", del4, 18'd0);
    check("rst rs", rs4, 1'b0);
    check("rst rq8", rq8_o, 1'b0);
    reset = 1'b0;

    // "AB" at address 0
    buf4[0] = 8'h41;
    buf4[1] = 8'h42;
    log4.delete();
    a0 = acks4;
    start(1'b0, 7'h00, 6'd2);
    check("A busy after accept", busy4, 1'b1);
    check("A rq_o lags state", rq4_o, 1'b0);
    wait_done(1'b0, a0);
    ex.delete();
    ex.push_back(mk(0, 8'h8, S)); ex.push_back(mk(0, 8'h0, L));
    ex.push_back(mk(1, 8'h4, S)); ex.push_back(mk(1, 8'h1, L));
    ex.push_back(mk(1, 8'h4, S)); ex.push_back(mk(1, 8'h2, L));
    cmp_log("A", log4, ex);
    check("A ack count", acks4 - a0, 1);
    check("A busy at ack", busyack4, 0);
    check("A charIdx hold", idx4, 5'd2);
    check("A rw", rw4, 1'b0);

    // Start near end of line 1
    buf4[0] = 8'h57; buf4[1] = 8'h58; buf4[2] = 8'h59; buf4[3] = 8'h5A;
    log4.delete();
    a0 = acks4;
    start(1'b0, 7'h0E, 6'd4);
    wait_done(1'b0, a0);
    ex.delete();
    ex.push_back(mk(0, 8'h8, S)); ex.push_back(mk(0, 8'hE, L));
    ex.push_back(mk(1, 8'h5, S)); ex.push_back(mk(1, 8'h7, L));
    ex.push_back(mk(1, 8'h5, S)); ex.push_back(mk(1, 8'h8, L));
`ifdef LCD_SEND_SEQ_WRAP_EN
    ex.push_back(mk(0, 8'hC, S)); ex.push_back(mk(0, 8'h0, L));
`endif
    ex.push_back(mk(1, 8'h5, S)); ex.push_back(mk(1, 8'h9, L));
    ex.push_back(mk(1, 8'h5, S)); ex.push_back(mk(1, 8'hA, L));
    cmp_log("B", log4, ex);
    check("B ack count", acks4 - a0, 1);
    check("B charIdx hold", idx4, 5'd4);

    // Zero-length string
    log4.delete();
    a0 = acks4;
    @(negedge clk);
    ads = 7'h11;
    len = 6'd0;
    rq4 = 1'b1;
    #1 check("Z no early ack", ack4_o, 1'b0);
    @(negedge clk);
    check("Z ack after accept", ack4_o, 1'b1);
    check("Z busy low at ack", busy4, 1'b0);
    check("Z rq_o idle", rq4_o, 1'b0);
    rq4 = 1'b0;
    @(negedge clk);
    check("Z ack one cycle", ack4_o, 1'b0);
    repeat (5) @(negedge clk);
    check("Z no requests", log4.size(), 0);
    check("Z ack count", acks4 - a0, 1);

    // Request held off by powerUp, then a second request while busy
    buf4[0] = 8'h33;
    log4.delete();
    a0 = acks4;
    @(negedge clk);
    pu  = 1'b1;
    rq4 = 1'b1;
    ads = 7'h20;
    len = 6'd1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rq4_o || busy4) seen++;
    end
    check("P held during powerUp", seen, 0);
    pu = 1'b0;
    @(negedge clk);
    check("P accept on powerUp fall", busy4, 1'b1);
    rq4 = 1'b0;
    repeat (4) @(negedge clk);
    rq4 = 1'b1;
    @(negedge clk);
    rq4 = 1'b0;
    wait_done(1'b0, a0);
    repeat (10) @(negedge clk);
    ex.delete();
    ex.push_back(mk(0, 8'hA, S)); ex.push_back(mk(0, 8'h0, L));
    ex.push_back(mk(1, 8'h3, S)); ex.push_back(mk(1, 8'h3, L));
    cmp_log("P", log4, ex);
    check("P ack count", acks4 - a0, 1);
    check("P idle after", busy4, 1'b0);

    // Asynchronous reset during DAT_HI
    buf4[0] = 8'h41;
    buf4[1] = 8'h42;
    log4.delete();
    a0 = acks4;
    start(1'b0, 7'h00, 6'd2);
    n = 0;
    while (!(log4.size() == 2 && rq4_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("R reach DAT_HI", n < 200, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("R rq_o async", rq4_o, 1'b0);
    check("R busy async", busy4, 1'b0);
    check("R ack async", ack4_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("R no ack after reset", acks4 - a0, 0);
    check("R no more requests", log4.size(), 2);
    log4.delete();
    a0 = acks4;
    start(1'b0, 7'h00, 6'd2);
    wait_done(1'b0, a0);
    ex.delete();
    ex.push_back(mk(0, 8'h8, S)); ex.push_back(mk(0, 8'h0, L));
    ex.push_back(mk(1, 8'h4, S)); ex.push_back(mk(1, 8'h1, L));
    ex.push_back(mk(1, 8'h4, S)); ex.push_back(mk(1, 8'h2, L));
    cmp_log("R rerun", log4, ex);
    check("R rerun ack", acks4 - a0, 1);

    // 8-bit bus at end of line 2
    buf8[0] = 8'h31;
    buf8[1] = 8'h32;
    log8.delete();
    a0 = acks8;
    start(1'b1, 7'h4F, 6'd2);
    wait_done(1'b1, a0);
    ex.delete();
    ex.push_back(mk(0, 8'hCF, L));
    ex.push_back(mk(1, 8'h31, L));
`ifdef LCD_SEND_SEQ_WRAP_EN
    ex.push_back(mk(0, 8'h80, L));
`endif
    ex.push_back(mk(1, 8'h32, L));
    cmp_log("W8", log8, ex);
    check("W8 ack count", acks8 - a0, 1);
    check("W8 busy at ack", busyack8, 0);
    check("W8 charIdx hold", idx8, 5'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
